// File: rtl/ber_test_sequencer.sv
// ber_test_sequencer
//
// Purpose:
//   Sequences one bit-error-rate measurement on the PRBS31 -> PAM-4 ->
//   channel -> DFE -> decode -> prbs31_checker loop. A run pulses the
//   datapath reset and enables the generator. It then discards a fixed
//   number of received symbols so the pipeline can fill and the checker
//   can lock. Finally it measures a programmable bit window, or stops
//   early once the error limit is exceeded, and latches the results.
//   This block is the only driver of the datapath enable and the
//   datapath reset.
//
// Optional feature:
//   BER_TEST_SEQUENCER_WDT_EN - adds a watchdog over FLUSH and MEASURE.
//   It exits to DONE after WDT_CYCLES cycles without an rx_valid pulse,
//   and it adds the 'timeout' output port.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   start, abort        run control (abort has priority over start)
//   window_bits         bits to measure, latched on an accepted start
//   err_limit           early-stop error threshold, latched on an accepted start
//   rx_valid            received symbol strobe from the decoder
//   total_bits          running bit count from the checker
//   total_bit_errors    running error count from the checker
//   gen_en              generator enable
//   chain_rstn          registered active-low datapath reset
//   busy, done          run status
//   meas_bits           bits counted in the window
//   meas_errors         errors counted in the window
//   limit_hit           run ended on the error limit
//   state_o             IDLE=0, RESET=1, FLUSH=2, MEASURE=3 (DONE reads as 0)
//   timeout             watchdog exit flag (only with BER_TEST_SEQUENCER_WDT_EN)

module ber_test_sequencer #(
    parameter int CNT_WIDTH    = 32,
    parameter int RST_CYCLES   = 4,
    parameter int FLUSH_VALIDS = 64,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] window_bits,
    input  logic [CNT_WIDTH-1:0] err_limit,
    input  logic                 rx_valid,
    input  logic [CNT_WIDTH-1:0] total_bits,
    input  logic [CNT_WIDTH-1:0] total_bit_errors,
    output logic                 gen_en,
    output logic                 chain_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] meas_bits,
    output logic [CNT_WIDTH-1:0] meas_errors,
    output logic                 limit_hit,
`ifdef BER_TEST_SEQUENCER_WDT_EN
    output logic [1:0]           state_o,
    output logic                 timeout
`else
    output logic [1:0]           state_o
`endif
);

    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int FLUSH_W = $clog2(FLUSH_VALIDS + 1);
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_VALIDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_FLUSH,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [RST_W-1:0]       rstCnt_q, rstCnt_d;
    logic [FLUSH_W-1:0]     flushCnt_q, flushCnt_d;
    logic [CNT_WIDTH-1:0]   windowBits_q, windowBits_d;
    logic [CNT_WIDTH-1:0]   errLimit_q, errLimit_d;
    logic [CNT_WIDTH-1:0]   baseBits_q, baseBits_d;
    logic [CNT_WIDTH-1:0]   baseErr_q, baseErr_d;
    logic [CNT_WIDTH-1:0]   measBits_q, measBits_d;
    logic [CNT_WIDTH-1:0]   measErrors_q, measErrors_d;
    logic                   limitHit_q, limitHit_d;
    logic                   genEn_q, genEn_d;
    logic                   chainRstn_q, chainRstn_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             stateO_q, stateO_d;

    // Window deltas use modulo subtraction so a checker counter that wraps
    // inside the window still gives the right distance from the baseline.
    logic [CNT_WIDTH-1:0]   dBits, dErr;
    logic                   errOver, winDone;

`ifdef BER_TEST_SEQUENCER_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0]       wdtCnt_q, wdtCnt_d;
    logic                   timeout_q, timeout_d;
    logic                   wdtExpire;
`endif

    // Next-state, result latching and registered-output computation.
    // Outputs are derived from the next state so they change on the same
    // edge as the state register.
    always_comb begin
        state_d      = state_q;
        rstCnt_d     = rstCnt_q;
        flushCnt_d   = flushCnt_q;
        windowBits_d = windowBits_q;
        errLimit_d   = errLimit_q;
        baseBits_d   = baseBits_q;
        baseErr_d    = baseErr_q;
        measBits_d   = measBits_q;
        measErrors_d = measErrors_q;
        limitHit_d   = limitHit_q;

        dBits   = total_bits - baseBits_q;
        dErr    = total_bit_errors - baseErr_q;
        errOver = (dErr > errLimit_q);
        winDone = (dBits >= windowBits_q);

`ifdef BER_TEST_SEQUENCER_WDT_EN
        timeout_d = timeout_q;
        wdtExpire = !rx_valid && (wdtCnt_q == WDT_LAST);
`endif

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_RESET;
                        rstCnt_d     = '0;
                        windowBits_d = window_bits;
                        errLimit_d   = err_limit;
                        measBits_d   = '0;
                        measErrors_d = '0;
                        limitHit_d   = 1'b0;
`ifdef BER_TEST_SEQUENCER_WDT_EN
                        timeout_d    = 1'b0;
`endif
                    end
                end
                S_RESET: begin
                    if (rstCnt_q == RST_LAST) begin
                        state_d    = S_FLUSH;
                        flushCnt_d = '0;
                    end else begin
                        rstCnt_d = rstCnt_q + RST_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (rx_valid) begin
                        if (flushCnt_q == FLUSH_LAST) begin
                            state_d    = S_MEASURE;
                            baseBits_d = total_bits;
                            baseErr_d  = total_bit_errors;
                        end else begin
                            flushCnt_d = flushCnt_q + FLUSH_W'(1);
                        end
                    end
`ifdef BER_TEST_SEQUENCER_WDT_EN
                    else if (wdtExpire) begin
                        state_d      = S_DONE;
                        measBits_d   = '0;
                        measErrors_d = '0;
                        limitHit_d   = 1'b0;
                        timeout_d    = 1'b1;
                    end
`endif
                end
                S_MEASURE: begin
                    // An error-limit stop takes precedence in limit_hit even
                    // when the window completes on the same cycle.
                    if (errOver || winDone) begin
                        state_d      = S_DONE;
                        measBits_d   = dBits;
                        measErrors_d = dErr;
                        limitHit_d   = errOver;
                    end
`ifdef BER_TEST_SEQUENCER_WDT_EN
                    else if (wdtExpire) begin
                        state_d      = S_DONE;
                        measBits_d   = dBits;
                        measErrors_d = dErr;
                        limitHit_d   = 1'b0;
                        timeout_d    = 1'b1;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef BER_TEST_SEQUENCER_WDT_EN
        if ((state_d != state_q) || rx_valid) begin
            wdtCnt_d = '0;
        end else if ((state_q == S_FLUSH) || (state_q == S_MEASURE)) begin
            wdtCnt_d = wdtCnt_q + WDT_W'(1);
        end else begin
            wdtCnt_d = wdtCnt_q;
        end
`endif

        genEn_d     = (state_d == S_FLUSH) || (state_d == S_MEASURE);
        chainRstn_d = (state_d != S_RESET);
        busy_d      = (state_d == S_RESET) || (state_d == S_FLUSH) || (state_d == S_MEASURE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_RESET:   stateO_d = 2'd1;
            S_FLUSH:   stateO_d = 2'd2;
            S_MEASURE: stateO_d = 2'd3;
            default:   stateO_d = 2'd0;
        endcase
    end

    // State, counters, latched configuration/results and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rstCnt_q     <= '0;
            flushCnt_q   <= '0;
            windowBits_q <= '0;
            errLimit_q   <= '0;
            baseBits_q   <= '0;
            baseErr_q    <= '0;
            measBits_q   <= '0;
            measErrors_q <= '0;
            limitHit_q   <= 1'b0;
            genEn_q      <= 1'b0;
            chainRstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stateO_q     <= 2'd0;
`ifdef BER_TEST_SEQUENCER_WDT_EN
            wdtCnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rstCnt_q     <= rstCnt_d;
            flushCnt_q   <= flushCnt_d;
            windowBits_q <= windowBits_d;
            errLimit_q   <= errLimit_d;
            baseBits_q   <= baseBits_d;
            baseErr_q    <= baseErr_d;
            measBits_q   <= measBits_d;
            measErrors_q <= measErrors_d;
            limitHit_q   <= limitHit_d;
            genEn_q      <= genEn_d;
            chainRstn_q  <= chainRstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stateO_q     <= stateO_d;
`ifdef BER_TEST_SEQUENCER_WDT_EN
            wdtCnt_q     <= wdtCnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign gen_en      = genEn_q;
    assign chain_rstn  = chainRstn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign meas_bits   = measBits_q;
    assign meas_errors = measErrors_q;
    assign limit_hit   = limitHit_q;
    assign state_o     = stateO_q;
`ifdef BER_TEST_SEQUENCER_WDT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Testbench for ber_test_sequencer.
// Each run pre-generates a random checker history: rx_valid strobes, and
// bit/error counters that advance by 2 bits per symbol with random errors.
// The expected run timeline and results are found by scanning that history
// with the sequencing rules: a reset phase, then a count of flushed symbols,
// then the first cycle at which the window or the error limit is met. The
// DUT is then driven cycle by cycle and its outputs are compared against
// that timeline.

module tb_ber_test_sequencer;

    localparam int CW    = 32;
    localparam int RST   = 4;
    localparam int FLUSH = 64;
    localparam int N     = 4096;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [CW-1:0] window_bits;
    logic [CW-1:0] err_limit;
    logic          rx_valid;
    logic [CW-1:0] total_bits;
    logic [CW-1:0] total_bit_errors;
    logic          gen_en;
    logic          chain_rstn;
    logic          busy;
    logic          done;
    logic [CW-1:0] meas_bits;
    logic [CW-1:0] meas_errors;
    logic          limit_hit;
    logic [1:0]    state_o;
`ifdef BER_TEST_SEQUENCER_WDT_EN
    logic          timeout;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] bitsArr[N];
    logic [31:0] errArr[N];
    logic        validArr[N];
    logic        startArr[N];
    logic [31:0] lastBits;

    ber_test_sequencer #(
        .CNT_WIDTH   (CW),
        .RST_CYCLES  (RST),
        .FLUSH_VALIDS(FLUSH),
        .WDT_CYCLES  (1024)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .window_bits     (window_bits),
        .err_limit       (err_limit),
        .rx_valid        (rx_valid),
        .total_bits      (total_bits),
        .total_bit_errors(total_bit_errors),
        .gen_en          (gen_en),
        .chain_rstn      (chain_rstn),
        .busy            (busy),
        .done            (done),
        .meas_bits       (meas_bits),
        .meas_errors     (meas_errors),
        .limit_hit       (limit_hit),
`ifdef BER_TEST_SEQUENCER_WDT_EN
        .state_o         (state_o),
        .timeout         (timeout)
`else
        .state_o         (state_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkStatus(input string tag, input logic [1:0] st, input logic g,
                               input logic c, input logic b, input logic d);
        checkOutput({tag, ".state"}, 32'(state_o), 32'(st));
        checkOutput({tag, ".gen_en"}, 32'(gen_en), 32'(g));
        checkOutput({tag, ".chain_rstn"}, 32'(chain_rstn), 32'(c));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
        checkOutput({tag, ".done"}, 32'(done), 32'(d));
    endtask

    // One complete run against a freshly generated random checker history.
    task automatic applyStimulus(input string tag, input logic [31:0] win, input logic [31:0] lim,
                                 input logic [31:0] bitsInit, input logic [31:0] errInit,
                                 input int errPct, input int validPct);
        int          eM;
        int          eD;
        int          cnt;
        logic [31:0] baseB;
        logic [31:0] baseE;
        logic [31:0] dB;
        logic [31:0] dE;
        logic [31:0] expB;
        logic [31:0] expE;
        logic        expL;
        logic [1:0]  eSt;
        logic        eG;
        logic        eC;
        logic        eB;
        logic        eDn;

        bitsArr[0] = bitsInit;
        errArr[0]  = errInit;
        for (int e = 0; e < N; e++) begin
            validArr[e] = (int'($urandom_range(99)) < validPct);
            startArr[e] = 1'b0;
            if (e + 1 < N) begin
                bitsArr[e+1] = bitsArr[e] + (validArr[e] ? 32'd2 : 32'd0);
                errArr[e+1]  = errArr[e] +
                               ((validArr[e] && (int'($urandom_range(99)) < errPct)) ? 32'd1 : 32'd0);
            end
        end

        // Symbols seen from the first FLUSH edge onward are flushed; the edge
        // of the last flushed symbol fixes the baseline.
        eM  = -1;
        cnt = 0;
        for (int e = RST + 1; e < N; e++) begin
            if (validArr[e]) begin
                cnt++;
                if (cnt == FLUSH) begin
                    eM = e;
                    break;
                end
            end
        end
        eD   = -1;
        expB = 0;
        expE = 0;
        expL = 0;
        if (eM >= 0) begin
            baseB = bitsArr[eM];
            baseE = errArr[eM];
            for (int e = eM + 1; e < N - 4; e++) begin
                dB = bitsArr[e] - baseB;
                dE = errArr[e] - baseE;
                if ((dE > lim) || (dB >= win)) begin
                    eD   = e;
                    expB = dB;
                    expE = dE;
                    expL = (dE > lim);
                    break;
                end
            end
        end
        lastBits = expB;
        if (eD < 0) begin
            checkOutput({tag, ".scan"}, 32'd0, 32'd1);
            return;
        end

        // Stray start pulses while busy must be ignored.
        startArr[0] = 1'b1;
        for (int e = 1; e < eD; e++) startArr[e] = ($urandom_range(9) == 0);

        for (int e = 0; e <= eD + 3; e++) begin
            start            = startArr[e];
            rx_valid         = validArr[e];
            total_bits       = bitsArr[e];
            total_bit_errors = errArr[e];
            if (e == 0) begin
                window_bits = win;
                err_limit   = lim;
            end else begin
                window_bits = $urandom;
                err_limit   = $urandom;
            end
            tick();
            if (e < RST) begin
                eSt = 2'd1; eG = 0; eC = 0; eB = 1; eDn = 0;
            end else if (e < eM) begin
                eSt = 2'd2; eG = 1; eC = 1; eB = 1; eDn = 0;
            end else if (e < eD) begin
                eSt = 2'd3; eG = 1; eC = 1; eB = 1; eDn = 0;
            end else begin
                eSt = 2'd0; eG = 0; eC = 1; eB = 0; eDn = 1;
            end
            checkStatus($sformatf("%s@%0d", tag, e), eSt, eG, eC, eB, eDn);
            if (e == 0) begin
                checkOutput({tag, ".clr_bits"}, meas_bits, 32'd0);
                checkOutput({tag, ".clr_errs"}, meas_errors, 32'd0);
                checkOutput({tag, ".clr_limit"}, 32'(limit_hit), 32'd0);
            end
            if (e >= eD) begin
                checkOutput($sformatf("%s.meas_bits@%0d", tag, e), meas_bits, expB);
                checkOutput($sformatf("%s.meas_errors@%0d", tag, e), meas_errors, expE);
                checkOutput($sformatf("%s.limit_hit@%0d", tag, e), 32'(limit_hit), 32'(expL));
            end
        end
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        rstn             = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        window_bits      = '0;
        err_limit        = '0;
        rx_valid         = 1'b0;
        total_bits       = '0;
        total_bit_errors = '0;
        lastBits         = '0;

        #12;
        checkStatus("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.meas_bits", meas_bits, 32'd0);
        checkOutput("reset.limit_hit", 32'(limit_hit), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checkStatus("idle", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clean channel, forced errors, counter wrap and window=0.
        applyStimulus("clean", 32'd1000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 60);
        applyStimulus("errs", 32'd10000, 32'd10, 32'd1234, 32'd77, 100, 70);
        applyStimulus("wrap", 32'd500, 32'hFFFF_FFFF, 32'hFFFF_FF9C - 32'd200, 32'hFFFF_FFFA, 10, 80);
        applyStimulus("win0", 32'd0, 32'hFFFF_FFFF, 32'd5000, 32'd0, 0, 50);
        for (int r = 0; r < 3; r++) begin
            applyStimulus($sformatf("rand%0d", r), 32'($urandom_range(1500)), 32'($urandom_range(30)),
                          $urandom, $urandom, int'($urandom_range(20)), 50 + int'($urandom_range(40)));
        end

        // Abort from DONE keeps the results.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkStatus("abortDone", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("abortDone.meas_bits", meas_bits, lastBits);

        // Abort during FLUSH.
        start       = 1'b1;
        window_bits = 32'd100;
        err_limit   = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < RST + 2; i++) tick();
        checkStatus("inFlush", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkStatus("abortFlush", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // start together with abort in IDLE stays in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkStatus("startAbort", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkStatus("startAbort2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of MEASURE.
        start       = 1'b1;
        window_bits = 32'hFFFF_FFFF;
        err_limit   = 32'hFFFF_FFFF;
        rx_valid    = 1'b1;
        for (int i = 0; i < RST + FLUSH + 8; i++) begin
            tick();
            start      = 1'b0;
            total_bits = total_bits + 32'd2;
        end
        checkStatus("measure", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        checkStatus("asyncReset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("asyncReset.meas_bits", meas_bits, 32'd0);
        checkOutput("asyncReset.meas_errors", meas_errors, 32'd0);
        checkOutput("asyncReset.limit_hit", 32'(limit_hit), 32'd0);
        rx_valid = 1'b0;
        #1;
        rstn = 1'b1;
        @(negedge clk);
        tick();
        checkStatus("afterReset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
